sw_toggle_encoder: RTL and testbench



---
 rtl/sw_toggle_encoder_if.sv | 13 +
 rtl/sw_toggle_encoder.sv | 139 +++++++++++++
 tb/tb_sw_toggle_encoder.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sw_toggle_encoder_if.sv
// Toggle-event handshake bundle: index + one-hot mask offered over valid/ready.
interface sw_toggle_encoder_if #(
  parameter int unsigned N_SW  = 10,
  parameter int unsigned IDX_W = 4
);
  logic              tog_valid;
  logic              tog_ready;
  logic [IDX_W-1:0]  tog_idx;
  logic [N_SW-1:0]   tog_mask;

  modport master (output tog_valid, output tog_idx, output tog_mask, input tog_ready);
  modport slave  (input tog_valid, input tog_idx, input tog_mask, output tog_ready);
endinterface

// File: rtl/sw_toggle_encoder.sv
// Synchronise, debounce and queue slide-switch flips as one-at-a-time toggle events.
// Optional SWT_CANCEL_CNT_EN adds cancel_cnt, a saturating count of flips cancelled in the queue.
module sw_toggle_encoder #(
  parameter int unsigned N_SW       = 10,
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned CNT_W      = 20,
  parameter int unsigned IDX_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_SW-1:0]      sw,
  output logic [N_SW-1:0]      sw_stable,
  sw_toggle_encoder_if.master  tog
`ifdef SWT_CANCEL_CNT_EN
  ,
  output logic [7:0]           cancel_cnt
`endif
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam int unsigned INIT_LAST = 2;

  state_t            state;
  logic [1:0]        init_cnt;
  logic [N_SW-1:0]   sync1;
  logic [N_SW-1:0]   sync2;
  logic [N_SW-1:0]   pending;
  logic [CNT_W-1:0]  cnt [N_SW];

  logic [N_SW-1:0]   flip_c;
  logic [N_SW-1:0]   grant_c;
  logic [IDX_W-1:0]  grant_idx_c;
  logic              grant_any_c;
  logic              load_c;

  // A flip fires on the DEB_CYCLES-th consecutive cycle of disagreement.
  always_comb begin
    flip_c = '0;
    if (state == S_RUN) begin
      for (int i = 0; i < N_SW; i++) begin
        if ((sync2[i] != sw_stable[i]) && (cnt[i] == CNT_W'(DEB_CYCLES - 1)))
          flip_c[i] = 1'b1;
      end
    end
  end

  // Lowest-index pending event wins the output slot.
  always_comb begin
    grant_idx_c = '0;
    for (int i = N_SW - 1; i >= 0; i--) begin
      if (pending[i])
        grant_idx_c = IDX_W'(i);
    end
    grant_any_c = |pending;
    load_c      = !tog.tog_valid || tog.tog_ready;
    grant_c     = (load_c && grant_any_c) ? (N_SW'(1) << grant_idx_c) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_INIT;
      init_cnt      <= '0;
      sync1         <= '0;
      sync2         <= '0;
      sw_stable     <= '0;
      pending       <= '0;
      tog.tog_valid <= 1'b0;
      tog.tog_idx   <= '0;
      tog.tog_mask  <= '0;
      for (int i = 0; i < N_SW; i++)
        cnt[i] <= '0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
      case (state)
        S_INIT: begin
          // Levels already present at reset become the baseline, not events.
          sw_stable     <= sync2;
          pending       <= '0;
          tog.tog_valid <= 1'b0;
          tog.tog_mask  <= '0;
          for (int i = 0; i < N_SW; i++)
            cnt[i] <= '0;
          if (init_cnt == 2'(INIT_LAST))
            state <= S_RUN;
          else
            init_cnt <= init_cnt + 2'd1;
        end
        S_RUN: begin
          for (int i = 0; i < N_SW; i++) begin
            if (sync2[i] == sw_stable[i]) begin
              cnt[i] <= '0;
            end else if (flip_c[i]) begin
              cnt[i]       <= '0;
              sw_stable[i] <= sync2[i];
            end else begin
              cnt[i] <= cnt[i] + CNT_W'(1);
            end
          end
          // A second flip of a still-pending switch cancels the first.
          pending <= (pending & ~grant_c) ^ flip_c;
          if (load_c) begin
            tog.tog_valid <= grant_any_c;
            if (grant_any_c) begin
              tog.tog_idx  <= grant_idx_c;
              tog.tog_mask <= grant_c;
            end else begin
              tog.tog_mask <= '0;
            end
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

`ifdef SWT_CANCEL_CNT_EN
  logic [4:0] cancel_inc_c;
  logic [8:0] cancel_sum_c;

  always_comb begin
    cancel_inc_c = '0;
    for (int i = 0; i < N_SW; i++)
      cancel_inc_c = cancel_inc_c + 5'(flip_c[i] & pending[i] & ~grant_c[i]);
    cancel_sum_c = 9'(cancel_cnt) + 9'(cancel_inc_c);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      cancel_cnt <= '0;
    else if (cancel_sum_c > 9'd255)
      cancel_cnt <= 8'hff;
    else
      cancel_cnt <= cancel_sum_c[7:0];
  end
`endif

endmodule

// File: tb/tb_sw_toggle_encoder.sv
// Bench for sw_toggle_encoder: directed scenarios plus randomized run against a reference model.
module tb_sw_toggle_encoder;
  localparam int unsigned N_SW  = 10;
  localparam int unsigned DEB   = 4;
  localparam int unsigned CNT_W = 20;
  localparam int unsigned IDX_W = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N_SW-1:0] sw = '0;
  logic [N_SW-1:0] sw_stable;
`ifdef SWT_CANCEL_CNT_EN
  logic [7:0]      cancel_cnt;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int          got[$];

  sw_toggle_encoder_if #(.N_SW(N_SW), .IDX_W(IDX_W)) tog_if ();

  sw_toggle_encoder #(
    .N_SW(N_SW), .DEB_CYCLES(DEB), .CNT_W(CNT_W), .IDX_W(IDX_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .sw_stable (sw_stable),
    .tog       (tog_if)
`ifdef SWT_CANCEL_CNT_EN
    ,
    .cancel_cnt(cancel_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Log every accepted event.
  always @(posedge clk)
    if (rst_n && tog_if.tog_valid && tog_if.tog_ready)
      got.push_back(int'(tog_if.tog_idx));

  // Reference model: debounce as "last DEB samples all disagree", queue as a set of pending switches.
  logic [N_SW-1:0]  m_s1, m_s2, m_stable, m_pend, m_mask, m_flip, m_grant;
  logic [N_SW-1:0]  m_hist [DEB];
  logic             m_valid;
  logic [IDX_W-1:0] m_idx;
  int               m_init, m_nrun, m_cancel;
  bit               all_diff;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_pend = '0; m_mask = '0;
      m_valid = 1'b0; m_idx = '0; m_init = 0; m_nrun = 0; m_cancel = 0;
      for (int k = 0; k < DEB; k++) m_hist[k] = '0;
    end else begin
      m_flip = '0;
      m_grant = '0;
      if (m_init < 3) begin
        m_stable = m_s2;
        m_init++;
        m_valid = 1'b0; m_mask = '0; m_pend = '0;
      end else begin
        for (int k = DEB - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = m_s2;
        if (m_nrun < DEB) m_nrun++;
        if (m_nrun >= DEB) begin
          for (int i = 0; i < N_SW; i++) begin
            all_diff = 1'b1;
            for (int k = 0; k < DEB; k++)
              if (m_hist[k][i] == m_stable[i]) all_diff = 1'b0;
            m_flip[i] = all_diff;
          end
        end
        if (!m_valid || tog_if.tog_ready) begin
          m_valid = 1'b0;
          for (int i = 0; i < N_SW; i++)
            if (m_pend[i] && !m_valid) begin
              m_valid = 1'b1; m_idx = IDX_W'(i); m_grant[i] = 1'b1;
            end
          m_mask = m_grant;
        end
        for (int i = 0; i < N_SW; i++)
          if (m_flip[i] && m_pend[i] && !m_grant[i] && m_cancel < 255) m_cancel++;
        m_pend   = (m_pend & ~m_grant) ^ m_flip;
        m_stable = m_stable ^ m_flip;
      end
      m_s2 = m_s1;
      m_s1 = sw;
    end
  end

  task automatic do_reset(input logic [N_SW-1:0] lvl);
    @(negedge clk);
    rst_n = 1'b0; sw = lvl;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    got.delete();
  endtask

  task automatic test_reset();
    int seen;
    @(negedge clk);
    rst_n = 1'b0; sw = 10'h201; tog_if.tog_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (tog_if.tog_valid !== 1'b0 || tog_if.tog_mask !== '0 || sw_stable !== '0 || tog_if.tog_idx !== '0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b mask=%h stable=%h idx=%0d expected all 0",
               tog_if.tog_valid, tog_if.tog_mask, sw_stable, tog_if.tog_idx);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (sw_stable !== 10'h201) begin
      n_fail++;
      $display("FAIL reset_capture: stable=%h expected 201", sw_stable);
    end
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (tog_if.tog_valid !== 1'b0) seen++;
    end
    n_tests++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL reset_no_event: valid cycles=%0d expected 0", seen);
    end
  endtask

  task automatic test_single_flip();
    int lat;
    do_reset('0);
    tog_if.tog_ready = 1'b1;
    sw[3] = 1'b1;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (sw_stable[3]) begin lat = c; break; end
    end
    n_tests++;
    if (lat < 6 || lat > 7) begin
      n_fail++;
      $display("FAIL flip_latency: got %0d cycles expected 6..7", lat);
    end
    @(negedge clk);
    n_tests++;
    if (tog_if.tog_valid !== 1'b1 || tog_if.tog_idx !== 4'd3 || tog_if.tog_mask !== 10'h008) begin
      n_fail++;
      $display("FAIL flip_event: valid=%b idx=%0d mask=%h expected 1/3/008",
               tog_if.tog_valid, tog_if.tog_idx, tog_if.tog_mask);
    end
    @(negedge clk);
    n_tests++;
    if (tog_if.tog_valid !== 1'b0 || tog_if.tog_mask !== '0) begin
      n_fail++;
      $display("FAIL flip_single_cycle: valid=%b mask=%h expected 0/000", tog_if.tog_valid, tog_if.tog_mask);
    end
  endtask

  task automatic test_glitch();
    got.delete();
    for (int k = 0; k < 6; k++) begin
      sw[5] = ~sw[5];
      repeat (2) @(negedge clk);
    end
    sw[5] = 1'b1;
    repeat (30) @(negedge clk);
    n_tests++;
    if (sw_stable !== 10'h028) begin
      n_fail++;
      $display("FAIL glitch_stable: stable=%h expected 028", sw_stable);
    end
    n_tests++;
    if (got.size() != 1 || got[0] != 5) begin
      n_fail++;
      $display("FAIL glitch_events: count=%0d first=%0d expected 1 event idx 5",
               got.size(), (got.size() > 0) ? got[0] : -1);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    bit found;
    got.delete();
    tog_if.tog_ready = 1'b0;
    sw = sw | 10'h201;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (tog_if.tog_valid) begin found = 1'b1; break; end
    end
    n_tests++;
    if (!found || tog_if.tog_idx !== 4'd0 || tog_if.tog_mask !== 10'h001) begin
      n_fail++;
      $display("FAIL b2b_first: found=%b idx=%0d mask=%h expected 1/0/001", found, tog_if.tog_idx, tog_if.tog_mask);
    end
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tog_if.tog_valid !== 1'b1 || tog_if.tog_idx !== 4'd0 || tog_if.tog_mask !== 10'h001) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL b2b_hold: unstable cycles=%0d expected 0", bad);
    end
    tog_if.tog_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (tog_if.tog_valid !== 1'b1 || tog_if.tog_idx !== 4'd9 || tog_if.tog_mask !== 10'h200) begin
      n_fail++;
      $display("FAIL b2b_second: valid=%b idx=%0d mask=%h expected 1/9/200",
               tog_if.tog_valid, tog_if.tog_idx, tog_if.tog_mask);
    end
    @(negedge clk);
    n_tests++;
    if (tog_if.tog_valid !== 1'b0 || got.size() != 2 || got[0] != 0 || got[1] != 9) begin
      n_fail++;
      $display("FAIL b2b_drain: valid=%b accepted=%0d expected 0 and 2 events (0,9)", tog_if.tog_valid, got.size());
    end
  endtask

  task automatic test_cancel();
    bit found;
    got.delete();
    tog_if.tog_ready = 1'b0;
    sw[0] = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (tog_if.tog_valid) begin found = 1'b1; break; end
    end
    sw[2] = 1'b1;
    repeat (10) @(negedge clk);
    sw[2] = 1'b0;
    repeat (10) @(negedge clk);
    n_tests++;
    if (!found || tog_if.tog_valid !== 1'b1 || tog_if.tog_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL cancel_slot: found=%b valid=%b idx=%0d expected 1/1/0", found, tog_if.tog_valid, tog_if.tog_idx);
    end
    tog_if.tog_ready = 1'b1;
    repeat (10) @(negedge clk);
    n_tests++;
    if (got.size() != 1 || got[0] != 0 || tog_if.tog_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel_events: count=%0d valid=%b expected 1 event idx 0 then idle", got.size(), tog_if.tog_valid);
    end
`ifdef SWT_CANCEL_CNT_EN
    n_tests++;
    if (cancel_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL cancel_cnt: got %0d expected 1", cancel_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int seen;
    bit found;
    tog_if.tog_ready = 1'b0;
    sw = sw ^ 10'h092;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (tog_if.tog_valid) begin found = 1'b1; break; end
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if (!found || tog_if.tog_idx !== 4'd1) begin
      n_fail++;
      $display("FAIL rstmid_setup: found=%b idx=%0d expected 1/1", found, tog_if.tog_idx);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if (tog_if.tog_valid !== 1'b0 || tog_if.tog_mask !== '0) begin
      n_fail++;
      $display("FAIL rstmid_clear: valid=%b mask=%h expected 0/000", tog_if.tog_valid, tog_if.tog_mask);
    end
    rst_n = 1'b1;
    tog_if.tog_ready = 1'b1;
    got.delete();
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (tog_if.tog_valid !== 1'b0) seen++;
    end
    n_tests++;
    if (seen != 0 || got.size() != 0 || sw_stable !== sw) begin
      n_fail++;
      $display("FAIL rstmid_empty: valid cycles=%0d events=%0d stable=%h expected 0/0/%h",
               seen, got.size(), sw_stable, sw);
    end
  endtask

  task automatic test_random();
    do_reset(N_SW'($urandom));
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      n_tests++;
      if (sw_stable !== m_stable || tog_if.tog_valid !== m_valid || tog_if.tog_mask !== m_mask ||
          (m_valid && tog_if.tog_idx !== m_idx)) begin
        n_fail++;
        $display("FAIL random cyc %0d: stable=%h/%h valid=%b/%b idx=%0d/%0d mask=%h/%h (got/expected)",
                 cyc, sw_stable, m_stable, tog_if.tog_valid, m_valid, tog_if.tog_idx, m_idx,
                 tog_if.tog_mask, m_mask);
      end
`ifdef SWT_CANCEL_CNT_EN
      n_tests++;
      if (cancel_cnt !== 8'(m_cancel)) begin
        n_fail++;
        $display("FAIL random_cancel cyc %0d: got %0d expected %0d", cyc, cancel_cnt, m_cancel);
      end
`endif
      for (int i = 0; i < N_SW; i++)
        if ($urandom_range(0, 15) == 0) sw[i] = ~sw[i];
      tog_if.tog_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 999) != 0);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tog_if.tog_ready = 1'b1;
    test_reset();
    test_single_flip();
    test_glitch();
    test_back_to_back();
    test_cancel();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
